// File: rtl/ram_3port_sched_pkg.sv
// Shared scheduler constants: streak counter width and the shared-port grant encoding.
// Pure definitions with no latency or backpressure of their own.
package ram_3port_sched_pkg;
    localparam int         STREAK_W = 4;
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_W    = 2'd1;
    localparam logic [1:0] GNT_A    = 2'd2;
endpackage

// File: rtl/ram_3port_dp.sv
// Dual-read RAM with one write port; registered reads, 1-cycle latency, no backpressure.
// A read in the same cycle as a write to the same address returns the old word.
module ram_3port_dp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
        read_data1 <= mem[read_addr1];
        read_data2 <= mem[read_addr2];
    end
endmodule

// File: rtl/ram_sched_arb.sv
// Shared write/read1 port arbiter: W has priority, and RA is forced through after MAX_WR_STREAK lost cycles.
// Grant is combinational from the valids and the streak state; the streak register updates on the rising edge.
module ram_sched_arb
    import ram_3port_sched_pkg::*;
#(
    parameter int MAX_WR_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic                rda_valid,
    output logic [1:0]          gnt,
    output logic [STREAK_W-1:0] streak_cnt
);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

    logic at_cap;

    assign at_cap = (streak_cnt == STREAK_MAX);

    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (rda_valid && (!wr_valid || at_cap)) begin
                gnt = GNT_A;
            end else if (wr_valid) begin
                gnt = GNT_W;
            end
        end
    end

    // Counts W wins while RA is waiting; an idle RA cycle forgives the streak.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_cnt <= '0;
        end else if (!rda_valid || gnt == GNT_A) begin
            streak_cnt <= '0;
        end else if (gnt == GNT_W && !at_cap) begin
            streak_cnt <= streak_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ram_3port_sched.sv
// Schedules one writer and two readers onto a 3-port RAM; read responses arrive 1 cycle after accept.
// W/RA stall on arbitration loss (RA at most MAX_WR_STREAK+1 cycles); RB and responses never stall.
module ram_3port_sched
    import ram_3port_sched_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 64,
    parameter int MAX_WR_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rda_valid,
    output logic                  rda_ready,
    input  logic [ADDR_WIDTH-1:0] rda_addr,
    output logic                  rda_rsp_valid,
    output logic [DATA_WIDTH-1:0] rda_rsp_data,
    input  logic                  rdb_valid,
    output logic                  rdb_ready,
    input  logic [ADDR_WIDTH-1:0] rdb_addr,
    output logic                  rdb_rsp_valid,
    output logic [DATA_WIDTH-1:0] rdb_rsp_data,
    output logic                  busy
);
    logic [1:0]            gnt;
    logic [STREAK_W-1:0]   streak_cnt;
    logic                  grant_w;
    logic                  grant_a;
    logic                  rdb_acc;
    logic                  rda_vld_q;
    logic                  rdb_vld_q;
    logic                  hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] read_data1;
    logic [DATA_WIDTH-1:0] read_data2;

    ram_sched_arb #(
        .MAX_WR_STREAK (MAX_WR_STREAK)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .rda_valid  (rda_valid),
        .gnt        (gnt),
        .streak_cnt (streak_cnt)
    );

    ram_3port_dp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk        (clk),
        .write_en   (grant_w),
        .write_addr (wr_addr),
        .write_data (wr_data),
        .read_addr1 (rda_addr),
        .read_addr2 (rdb_addr),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    assign grant_w   = (gnt == GNT_W);
    assign grant_a   = (gnt == GNT_A);
    assign wr_ready  = grant_w;
    assign rda_ready = grant_a;
    assign rdb_ready = ~rst;
    assign rdb_acc   = rdb_valid & ~rst;

    // The RAM returns the pre-write word on a same-address collision, so RB takes the write data instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            rda_vld_q <= 1'b0;
            rdb_vld_q <= 1'b0;
            hit       <= 1'b0;
            fwd_data  <= '0;
        end else begin
            rda_vld_q <= grant_a;
            rdb_vld_q <= rdb_acc;
            hit       <= grant_w & rdb_acc & (wr_addr == rdb_addr);
            if (grant_w && rdb_acc && wr_addr == rdb_addr) begin
                fwd_data <= wr_data;
            end
        end
    end

    // Masking with rst drops a response whose request was accepted just before reset.
    assign rda_rsp_valid = rda_vld_q & ~rst;
    assign rdb_rsp_valid = rdb_vld_q & ~rst;
    assign rda_rsp_data  = read_data1;
    assign rdb_rsp_data  = hit ? fwd_data : read_data2;

    assign busy = wr_valid | rda_valid | rdb_valid | rda_rsp_valid | rdb_rsp_valid;

    logic unused_ok;
    assign unused_ok = ^streak_cnt;
endmodule

// File: tb/tb_ram_3port_sched.sv
// Randomized and directed check of ram_3port_sched against a memory-array reference model.
module tb_ram_3port_sched;
    localparam int AW  = 6;
    localparam int DW  = 64;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0, wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rda_valid = 1'b0, rda_ready;
    logic [AW-1:0] rda_addr = '0;
    logic          rda_rsp_valid;
    logic [DW-1:0] rda_rsp_data;
    logic          rdb_valid = 1'b0, rdb_ready;
    logic [AW-1:0] rdb_addr = '0;
    logic          rdb_rsp_valid;
    logic [DW-1:0] rdb_rsp_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    ram_3port_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WR_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rda_valid(rda_valid), .rda_ready(rda_ready), .rda_addr(rda_addr),
        .rda_rsp_valid(rda_rsp_valid), .rda_rsp_data(rda_rsp_data),
        .rdb_valid(rdb_valid), .rdb_ready(rdb_ready), .rdb_addr(rdb_addr),
        .rdb_rsp_valid(rdb_rsp_valid), .rdb_rsp_data(rdb_rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: memory contents, which words are defined, and responses owed next cycle.
    logic [DW-1:0] mem   [1 << AW];
    bit            known [1 << AW];
    bit            a_pend = 0, b_pend = 0, a_known = 0, b_known = 0;
    logic [DW-1:0] a_dat = '0, b_dat = '0;
    int            ra_lost = 0;
    int            ra_age  = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check everything visible this cycle, then advance the model past the edge.
    task automatic step(input bit r, input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit av, input logic [AW-1:0] aa, input bit bv, input logic [AW-1:0] ba,
                        output bit gw, output bit ga);
        bit exp_av, exp_bv;
        @(negedge clk);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rda_valid = av; rda_addr = aa; rdb_valid = bv; rdb_addr = ba;
        #1;
        ga = !r && av && (!wv || ra_lost == MAX);
        gw = !r && wv && !ga;
        check("wr_ready", 64'(wr_ready), 64'(gw));
        check("rda_ready", 64'(rda_ready), 64'(ga));
        check("rdb_ready", 64'(rdb_ready), 64'(!r));
        exp_av = a_pend && !r;
        exp_bv = b_pend && !r;
        check("rda_rsp_valid", 64'(rda_rsp_valid), 64'(exp_av));
        check("rdb_rsp_valid", 64'(rdb_rsp_valid), 64'(exp_bv));
        if (exp_av && a_known) check("rda_rsp_data", rda_rsp_data, a_dat);
        if (exp_bv && b_known) check("rdb_rsp_data", rdb_rsp_data, b_dat);
        check("busy", 64'(busy), 64'(wv | av | bv | exp_av | exp_bv));

        if (av && !r) ra_age++;
        if (ga) begin
            check("ra_wait_bound", 64'(ra_age <= MAX + 1), 64'(1));
            ra_age = 0;
        end
        if (!av || r) ra_age = 0;

        a_pend = ga; a_dat = mem[aa]; a_known = known[aa];
        b_pend = bv && !r;
        if (gw && wa == ba) begin
            b_dat = wd; b_known = 1;
        end else begin
            b_dat = mem[ba]; b_known = known[ba];
        end
        if (gw) begin
            mem[wa] = wd; known[wa] = 1;
        end
        ra_lost = (r || !av || ga) ? 0 : ra_lost + 1;
    endtask

    initial begin
        bit gw, ga;
        bit hw, ha;
        logic [AW-1:0] wa, aa;
        logic [DW-1:0] wd;

        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = '0; known[i] = 0;
        end

        // Reset, then idle with reset released.
        step(1, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        step(1, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        step(0, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        check("idle_busy", 64'(busy), 64'(0));

        // Full fill with addr*3, then both readers sweep every address back-to-back.
        for (int i = 0; i < 64; i++) step(0, 1, AW'(i), DW'(i * 3), 0, 0, 0, 0, gw, ga);
        for (int i = 0; i <= 64; i++) step(0, 0, 0, 0, i < 64, AW'(i), i < 64, AW'(63 - (i % 64)), gw, ga);

        // Write then read on the next cycle.
        step(0, 1, 6'h03, 64'hDEAD_BEEF, 0, 0, 0, 0, gw, ga);
        step(0, 0, 0, 0, 1, 6'h03, 0, 0, gw, ga);
        step(0, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        check("wr_rd_data", rda_rsp_data, 64'hDEAD_BEEF);

        // Same-cycle write/RB read: forwarded, then a non-colliding address keeps old contents.
        step(0, 1, 6'h05, 64'h1111, 0, 0, 1, 6'h05, gw, ga);
        step(0, 1, 6'h05, 64'h2222, 0, 0, 1, 6'h06, gw, ga);
        check("fwd_data", rdb_rsp_data, 64'h1111);
        step(0, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        check("nofwd_data", rdb_rsp_data, 64'(6 * 3));

        // W and RA both held valid: W,W,W,W,A repeating.
        for (int i = 0; i < 15; i++) begin
            step(0, 1, 6'h20, 64'h77, 1, 6'h21, 0, 0, gw, ga);
            check("streak_pattern", 64'(ga), 64'((i % 5) == 4));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, gw, ga);

        // RA accepted right before reset: the response is dropped, a fresh read still works.
        step(0, 0, 0, 0, 1, 6'h10, 0, 0, gw, ga);
        step(1, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        step(0, 0, 0, 0, 1, 6'h10, 0, 0, gw, ga);
        step(0, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        check("post_rst_data", rda_rsp_data, 64'(16 * 3));

        // Random traffic on a narrow address range so collisions are frequent; payloads held until ready.
        hw = 0; ha = 0; wa = '0; aa = '0; wd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!hw) begin
                hw = ($urandom_range(0, 2) != 0);
                wa = AW'($urandom_range(0, 7));
                wd = {$urandom, $urandom};
            end
            if (!ha) begin
                ha = ($urandom_range(0, 1) != 0);
                aa = AW'($urandom_range(0, 7));
            end
            step(0, hw, wa, wd, ha, aa, $urandom_range(0, 1) != 0, AW'($urandom_range(0, 7)), gw, ga);
            if (gw) hw = 0;
            if (ga) ha = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, gw, ga);
        step(0, 0, 0, 0, 0, 0, 0, 0, gw, ga);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
